icdf_interp_pipe: RTL and testbench
===================================

Name: icdf_interp_pipe

Overview:
Parametrised, pipelined inverse-CDF unit that maps a uniform sample (e.g. Sobol output) to a signed Gaussian-distributed value. It uses half-table folding around 0.5, a run-time programmable magnitude table, and optional linear interpolation between table entries. It sits between the Sobol sequence generator and downstream consumers. It has valid/ready handshakes on both sides and sustains one sample per cycle.

Parameters:
IN_W, 32, uniform input width; MSB selects the half (1 means u >= 0.5).
ADDR_W, 6, table index bits; the table holds 2^ADDR_W+1 entries (indices 0..2^ADDR_W).
FRAC_W, 8, interpolation fraction bits; requires ADDR_W+FRAC_W <= IN_W-1.
MAG_W, 12, unsigned table-entry and magnitude width.
OUT_W, MAG_W+1, signed two's-complement output width.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_data  in  IN_W  uniform sample u
in_valid  in  1  sample present
in_ready  out  1  unit accepts sample this cycle
interp_en  in  1  1 = linear interpolation, 0 = nearest-lower entry; sampled with each accepted input
tbl_we  in  1  table write strobe
tbl_addr  in  ADDR_W+1  table entry index
tbl_wdata  in  MAG_W  table entry magnitude
out_data  out  OUT_W  signed ICDF result
out_valid  out  1  result present
out_ready  in  1  downstream accepts result

Behaviour:
- Reset is synchronous on rst_n=0. It clears all table entries to 0, clears all stage valids (out_valid=0), and sets out_data=0. in_ready=1 on the cycle after reset deasserts.
- A reset asserted mid-operation discards all in-flight samples. No output is produced for them.
- Folding: s = u[IN_W-1]; r = u[IN_W-2:0].
  - m = r if s=1, else m = ~r (bitwise, IN_W-1 bits).
  - k = m[IN_W-2 -: ADDR_W]; f = m[IN_W-2-ADDR_W -: FRAC_W]. Remaining lower bits are ignored.
- Magnitude:
  - d = T[k+1] - T[k], signed MAG_W+1 bits.
  - p = (d * f) >>> FRAC_W, arithmetic shift, floor.
  - mag = T[k] + p, clamped to [0, 2^MAG_W-1].
  - If interp_en=0: mag = T[k].
- Output: out_data = +mag if s=1, else -mag (two's complement, OUT_W bits). -0 is 0.
- Pipeline, 3 stages:
  - S1: fold, read T[k] and T[k+1], register s, f, interp_en.
  - S2: multiply and shift.
  - S3: add, clamp, sign, register out_data/out_valid.
- Latency is 3 cycles from an accepted input (in_valid && in_ready) to out_valid with no stall.
- Handshake:
  - stall = out_valid && !out_ready; in_ready = !stall.
  - On stall, all stages and out_data hold unchanged.
  - Bubbles propagate normally, so throughput is 1 sample per cycle.
- out_data is stable while out_valid=1 and out_ready=0.
- Table writes:
  - Writes apply at the clock edge and are accepted in any cycle, including during a stall.
  - An S1 read in the same cycle as a write to the same address returns the old value.
  - tbl_addr > 2^ADDR_W is ignored.
- The table is never modified by lookups. Entries are not required to be monotonic; the clamp handles negative sums.
- k+1 never exceeds 2^ADDR_W, so no wrap-around occurs.
- Boundaries:
  - u=2^(IN_W-1) and u=2^(IN_W-1)-1 both give m=0.
  - u all-ones and u all-zeros both give k=2^ADDR_W-1, f=2^FRAC_W-1 (the largest-magnitude tails).

Test Plan:
(Defaults used throughout. Table loaded with T[k]=16*k for k=0..64.)
1. u=0x8000_0000 and u=0x7FFF_FFFF, interp_en=1 -> out_data=0 for both, each 3 cycles after acceptance.
2. u=0xC000_0000 -> +512 (13'h0200). u=0xC100_0000 -> k=32, f=128, result +520 (13'h0208). u=0x3EFF_FFFF -> -520 (13'h1DF8). With interp_en=0, u=0xC100_0000 -> +512.
3. u=0xFFFF_FFFF -> 1008+15 = +1023 (13'h03FF). u=0x0000_0000 -> -1023 (13'h1C01). Load T[64]=4095 and T[63]=4095 -> u=0xFFFF_FFFF gives 4095 with no overflow.
4. Streaming: 8 back-to-back samples with out_ready held low for 4 cycles mid-stream -> in_ready drops, out_data is held, and all 8 results appear in order with none lost or duplicated.
5. Write/read collision: write T[32]=100 in the same cycle S1 reads k=32 -> that sample uses 512. The next sample uses 100. Write to tbl_addr=65 -> no table change.
6. Assert rst_n=0 for 1 cycle with 3 samples in flight -> out_valid=0 next cycle, no stale outputs, and all lookups return 0 until the table is reloaded.

Source files
------------

// File: rtl/icdf_interp_pipe.sv
// Pipelined inverse-CDF: folds a uniform sample around 0.5, looks up a programmable
// magnitude table and optionally interpolates linearly between adjacent entries.
module icdf_interp_pipe #(
   parameter int IN_W   = 32,
   parameter int ADDR_W = 6,
   parameter int FRAC_W = 8,
   parameter int MAG_W  = 12,
   parameter int OUT_W  = MAG_W + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [IN_W-1:0]   in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              interp_en,
   input  logic              tbl_we,
   input  logic [ADDR_W:0]   tbl_addr,
   input  logic [MAG_W-1:0]  tbl_wdata,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int N_ENT = (1 << ADDR_W) + 1;
   localparam int LOW_W = IN_W - 1 - ADDR_W - FRAC_W;
   localparam int PW    = MAG_W + FRAC_W + 2;
   localparam int SW    = MAG_W + 2;
   localparam logic [ADDR_W:0] TOP_ADDR = (ADDR_W+1)'(1 << ADDR_W);

   logic [MAG_W-1:0] tbl [N_ENT];

   logic adv;
   assign in_ready = !(out_valid && !out_ready);
   assign adv      = in_ready;

   // stage 0: fold around 0.5 so both halves index the same half-table
   logic              s0;
   logic [IN_W-2:0]   r0, m0;
   logic [ADDR_W-1:0] k0;
   logic [ADDR_W:0]   k0p1;
   logic [FRAC_W-1:0] f0;

   assign s0   = in_data[IN_W-1];
   assign r0   = in_data[IN_W-2:0];
   assign m0   = s0 ? r0 : ~r0;
   assign k0   = m0[IN_W-2 -: ADDR_W];
   assign f0   = m0[IN_W-2-ADDR_W -: FRAC_W];
   assign k0p1 = {1'b0, k0} + (ADDR_W+1)'(1);

   generate
      if (LOW_W > 0) begin : g_low
         logic unused_low;
         assign unused_low = ^m0[LOW_W-1:0];
      end
   endgenerate

   logic              s1_valid, s1_s, s1_ie;
   logic [FRAC_W-1:0] s1_f;
   logic [MAG_W-1:0]  s1_t0, s1_t1;

   // stage 2: signed slope times fraction, floor via dropping low bits
   logic signed [MAG_W:0]   d1;
   logic signed [PW-1:0]    prod1;
   logic signed [MAG_W:0]   p1;
   logic                    unused_prod;

   assign d1    = $signed({1'b0, s1_t1}) - $signed({1'b0, s1_t0});
   assign prod1 = PW'(d1) * PW'($signed({1'b0, s1_f}));
   assign p1    = prod1[MAG_W+FRAC_W:FRAC_W];
   assign unused_prod = prod1[PW-1] ^ (^prod1[FRAC_W-1:0]);

   logic                  s2_valid, s2_s, s2_ie;
   logic [MAG_W-1:0]      s2_t0;
   logic signed [MAG_W:0] s2_p;

   // stage 3: add, clamp to [0, 2^MAG_W-1], apply sign
   logic signed [SW-1:0] sum2;
   logic [MAG_W-1:0]     mag2;
   logic [OUT_W-1:0]     mag_ext, res2;

   assign sum2 = SW'($signed({1'b0, s2_t0})) + SW'(s2_p);

   always_comb begin
      mag2 = s2_t0;
      if (s2_ie) begin
         if (sum2[SW-1])
            mag2 = '0;
         else if (sum2[MAG_W])
            mag2 = '1;
         else
            mag2 = sum2[MAG_W-1:0];
      end
   end

   assign mag_ext = OUT_W'(mag2);
   assign res2    = s2_s ? mag_ext : -mag_ext;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (adv) begin
         s1_valid  <= in_valid;
         s2_valid  <= s1_valid;
         out_valid <= s2_valid;
         if (s2_valid)
            out_data <= res2;
      end
   end

   always_ff @(posedge clk) begin
      if (adv) begin
         s1_s  <= s0;
         s1_ie <= interp_en;
         s1_f  <= f0;
         s1_t0 <= tbl[k0];
         s1_t1 <= tbl[k0p1];
         s2_s  <= s1_s;
         s2_ie <= s1_ie;
         s2_t0 <= s1_t0;
         s2_p  <= p1;
      end
   end

   // table reads above see the pre-write contents on a same-cycle write
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N_ENT; i++)
            tbl[i] <= '0;
      end else if (tbl_we && tbl_addr <= TOP_ADDR) begin
         tbl[tbl_addr] <= tbl_wdata;
      end
   end

endmodule

// File: tb/tb_icdf_interp_pipe.sv
// Directed plus randomized check of icdf_interp_pipe against an arithmetic reference
// model of the folded, interpolated table lookup.
module tb_icdf_interp_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        interp_en;
   logic        tbl_we;
   logic [6:0]  tbl_addr;
   logic [11:0] tbl_wdata;
   logic [12:0] out_data;
   logic        out_valid;
   logic        out_ready;

   icdf_interp_pipe dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .interp_en(interp_en),
      .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   localparam longint HALF = 64'sd2147483648;

   int          n_vec = 0;
   int          n_err = 0;
   logic [12:0] exp_q[$];
   int          mtbl[65];
   bit          last_acc;
   logic [12:0] last_out;
   bit          prev_stall;
   logic [12:0] prev_data;

   function automatic logic [12:0] ref_icdf(input logic [31:0] u, input bit ie);
      longint uu, m, k, f, t0, t1, prod, p, mag;
      uu = longint'(u);
      if (uu >= HALF) m = uu - HALF;
      else            m = HALF - 1 - uu;
      k  = m / 33554432;
      f  = (m / 131072) % 256;
      t0 = mtbl[k];
      t1 = mtbl[k+1];
      if (!ie) mag = t0;
      else begin
         prod = (t1 - t0) * f;
         p = prod / 256;
         if (prod < 0 && (prod % 256) != 0) p = p - 1;
         mag = t0 + p;
         if (mag < 0) mag = 0;
         if (mag > 4095) mag = 4095;
      end
      if (u[31]) return 13'(mag);
      else       return 13'(-mag);
   endfunction

   task automatic cycle(input bit iv, input logic [31:0] u, input bit ie, input bit ordy,
                        input bit we, input logic [6:0] wa, input logic [11:0] wd);
      logic [12:0] e;
      bit exp_rdy;
      @(negedge clk);
      in_valid = iv; in_data = u; interp_en = ie; out_ready = ordy;
      tbl_we = we; tbl_addr = wa; tbl_wdata = wd;
      #1;
      if (prev_stall) begin
         n_vec++;
         assert (out_valid === 1'b1 && out_data === prev_data)
         else begin n_err++; $error("FAIL hold: valid=%b data=%h, required valid=1 data=%h", out_valid, out_data, prev_data); end
      end
      exp_rdy = !((out_valid === 1'b1) && !ordy);
      n_vec++;
      assert (in_ready === exp_rdy)
      else begin n_err++; $error("FAIL in_ready: got %b, required %b", in_ready, exp_rdy); end
      if (out_valid === 1'b1 && ordy) begin
         n_vec++;
         assert (exp_q.size() > 0)
         else begin n_err++; $error("FAIL spurious_out: got data=%h, required no output", out_data); end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            assert (out_data === e)
            else begin n_err++; $error("FAIL out_data: got %h, required %h", out_data, e); end
         end
         last_out = out_data;
      end
      prev_stall = (out_valid === 1'b1) && !ordy;
      prev_data  = out_data;
      last_acc   = iv && (in_ready === 1'b1);
      if (last_acc) exp_q.push_back(ref_icdf(u, ie));
      if (we && wa <= 7'd64) mtbl[wa] = int'(wd);
   endtask

   task automatic idle(input bit ordy);
      cycle(1'b0, 32'h0, 1'b0, ordy, 1'b0, 7'd0, 12'd0);
   endtask

   task automatic send_check(input logic [31:0] u, input bit ie, input logic [12:0] expc, input string tag);
      cycle(1'b1, u, ie, 1'b1, 1'b0, 7'd0, 12'd0);
      n_vec++;
      assert (last_acc) else begin n_err++; $error("FAIL %s_accept: got in_ready=0, required 1", tag); end
      for (int i = 1; i <= 3; i++) begin
         idle(1'b1);
         n_vec++;
         assert (out_valid === (i == 3))
         else begin n_err++; $error("FAIL %s_latency: cycle %0d out_valid=%b, required %b", tag, i, out_valid, (i == 3)); end
      end
      n_vec++;
      assert (last_out === expc)
      else begin n_err++; $error("FAIL %s: got %h, required %h", tag, last_out, expc); end
   endtask

   task automatic load_linear();
      for (int k = 0; k <= 64; k++)
         cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 7'(k), 12'(16 * k));
   endtask

   task automatic drain(input string tag);
      int t = 0;
      while (exp_q.size() > 0 && t < 50) begin idle(1'b1); t++; end
      n_vec++;
      assert (exp_q.size() == 0)
      else begin n_err++; $error("FAIL %s_drain: %0d results missing, required 0", tag, exp_q.size()); end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; tbl_we = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      for (int i = 0; i < 65; i++) mtbl[i] = 0;
      prev_stall = 1'b0;
      #1;
      n_vec++;
      assert (out_valid === 1'b0 && out_data === 13'h0 && in_ready === 1'b1)
      else begin n_err++; $error("FAIL reset_state: valid=%b data=%h rdy=%b, required 0/0000/1", out_valid, out_data, in_ready); end
   endtask

   function automatic logic [31:0] rand_u();
      logic [31:0] b [4];
      b[0] = 32'h8000_0000; b[1] = 32'h7FFF_FFFF; b[2] = 32'hFFFF_FFFF; b[3] = 32'h0000_0000;
      if ($urandom_range(0, 7) == 0) return b[$urandom_range(0, 3)];
      return $urandom;
   endfunction

   initial begin
      logic [31:0] su [8];
      int i, t;
      bit saw_block;

      rst_n = 1'b0; in_data = '0; in_valid = 1'b0; interp_en = 1'b0;
      tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0; out_ready = 1'b1;
      prev_stall = 1'b0; last_out = '0; prev_data = '0;
      for (int k = 0; k < 65; k++) mtbl[k] = 0;
      repeat (2) @(posedge clk);
      do_reset();

      load_linear();
      send_check(32'h8000_0000, 1'b1, 13'h0000, "mid_hi");
      send_check(32'h7FFF_FFFF, 1'b1, 13'h0000, "mid_lo");
      send_check(32'hC000_0000, 1'b1, 13'h0200, "k32_f0");
      send_check(32'hC100_0000, 1'b1, 13'h0208, "k32_f128");
      send_check(32'h3EFF_FFFF, 1'b1, 13'h1DF8, "neg_k32_f128");
      send_check(32'hC100_0000, 1'b0, 13'h0200, "nointerp");
      send_check(32'hFFFF_FFFF, 1'b1, 13'h03FF, "tail_pos");
      send_check(32'h0000_0000, 1'b1, 13'h1C01, "tail_neg");
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 7'd64, 12'd4095);
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 7'd63, 12'd4095);
      send_check(32'hFFFF_FFFF, 1'b1, 13'h0FFF, "tail_full");

      load_linear();
      for (int k = 0; k < 8; k++) su[k] = $urandom;
      i = 0; t = 0; saw_block = 1'b0;
      while (i < 8 && t < 40) begin
         cycle(1'b1, su[i], 1'b1, !(t >= 4 && t < 8), 1'b0, 7'd0, 12'd0);
         if (last_acc) i++;
         else saw_block = 1'b1;
         t++;
      end
      n_vec++;
      assert (i == 8 && saw_block)
      else begin n_err++; $error("FAIL stream: accepted %0d blocked=%b, required 8 and 1", i, saw_block); end
      drain("stream");

      cycle(1'b1, 32'hC000_0000, 1'b1, 1'b1, 1'b1, 7'd32, 12'd100);
      cycle(1'b1, 32'hC000_0000, 1'b1, 1'b1, 1'b0, 7'd0, 12'd0);
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 7'd65, 12'd777);
      drain("collide");
      send_check(32'hC000_0000, 1'b1, 13'd100, "after_write");
      send_check(32'hFFFF_FFFF, 1'b1, 13'h03FF, "addr65_ignored");

      for (int k = 0; k < 3; k++) cycle(1'b1, $urandom, 1'b1, 1'b1, 1'b0, 7'd0, 12'd0);
      do_reset();
      for (int k = 0; k < 5; k++) begin
         idle(1'b1);
         n_vec++;
         assert (out_valid === 1'b0)
         else begin n_err++; $error("FAIL stale_out: got out_valid=%b data=%h, required 0", out_valid, out_data); end
      end
      send_check(32'hFFFF_FFFF, 1'b1, 13'h0000, "cleared_pos");
      send_check(32'h0000_0000, 1'b1, 13'h0000, "cleared_neg");
      send_check(32'hC100_0000, 1'b0, 13'h0000, "cleared_mid");

      for (int k = 0; k <= 64; k++)
         cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 7'(k), 12'($urandom_range(0, 4095)));
      for (int n = 0; n < 400; n++) begin
         cycle($urandom_range(0, 3) != 0, rand_u(), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
               7'($urandom_range(0, 70)), 12'($urandom_range(0, 4095)));
      end
      drain("random");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
